// File: rtl/da_fir_seq.sv
// da_fir_seq: bit-serial distributed-arithmetic sequencer for a 64-tap DA FIR.
// Holds the sample delay line and drives the external combinational coefficient
// LUTs with one bit-plane of the delay line per cycle. It then shift-accumulates
// the summed LUT outputs into one filtered result per accepted sample.
// The MSB plane is the sign plane of the two's complement samples, so its
// weighted LUT sum is subtracted rather than added.
module da_fir_seq #(
  parameter int DATA_W = 16,
  parameter int TAPS   = 64,
  parameter int LUTS   = 8,
  parameter int LUT_W  = 32,
  parameter int ACC_W  = 48
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    clear,
  output logic [TAPS-1:0]         lut_addr,
  input  logic [LUTS*LUT_W-1:0]   lut_data,
  output logic [ACC_W-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);

  // Bit-plane counter only needs to index 0..DATA_W-1; it is reloaded on every accept.
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_reg, state_next;
  logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [ACC_W-1:0]  acc_reg, acc_next;
  logic [DATA_W-1:0] x_reg [TAPS];

  logic              run;
  logic              in_fire;
  logic [ACC_W-1:0]  lut_ext [LUTS];
  logic [ACC_W-1:0]  plane_sum;
  logic [ACC_W-1:0]  plane_term;

  assign run      = (state_reg == ST_RUN);
  assign in_ready = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  // acc_reg holds partial sums during RUN; only expose it once it is final.
  assign out_data = out_valid ? acc_reg : '0;
  // clear overrides a handshake in the same cycle, so the sample is dropped.
  assign in_fire  = in_ready & in_valid & ~clear;

  genvar gi;

  // Each LUT word is sign-extended to the accumulator width before summing.
  generate
    for (gi = 0; gi < LUTS; gi++) begin : g_ext
      assign lut_ext[gi] = ACC_W'($signed(lut_data[LUT_W*gi +: LUT_W]));
    end
  endgenerate

  // Address bit t selects bit-plane bit_cnt of tap t; forced low outside RUN.
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_addr
      assign lut_addr[gi] = run & x_reg[gi][bit_cnt_reg];
    end
  endgenerate

  // Combinational sum of all LUT outputs for the current bit-plane, weighted by 2^bit.
  always_comb begin
    plane_sum = '0;
    for (int j = 0; j < LUTS; j++) begin
      plane_sum = plane_sum + lut_ext[j];
    end
    plane_term = plane_sum << bit_cnt_reg;
  end

  // Next-state, bit counter and accumulator update; clear beats every other event.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    acc_next     = acc_reg;
    if (clear) begin
      state_next   = ST_IDLE;
      bit_cnt_next = '0;
      acc_next     = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            state_next   = ST_RUN;
            bit_cnt_next = '0;
            acc_next     = '0;
          end
        end
        ST_RUN: begin
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == LAST_BIT) begin
            // Sign plane carries weight -2^(DATA_W-1).
            acc_next   = acc_reg - plane_term;
            state_next = ST_DONE;
          end else begin
            acc_next = acc_reg + plane_term;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_next = ST_IDLE;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Control and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      bit_cnt_reg <= '0;
      acc_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      acc_reg     <= acc_next;
    end
  end

  // Sample delay line: x[0] newest, shifts once per accepted sample, zeroed by clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < TAPS; t++) begin
        x_reg[t] <= '0;
      end
    end else if (clear) begin
      for (int t = 0; t < TAPS; t++) begin
        x_reg[t] <= '0;
      end
    end else if (in_fire) begin
      x_reg[0] <= in_data;
      for (int t = 1; t < TAPS; t++) begin
        x_reg[t] <= x_reg[t-1];
      end
    end
  end

endmodule

// File: tb/tb_da_fir_seq.sv
// tb_da_fir_seq: scoreboard bench for da_fir_seq with a behavioural model of
// the eight external coefficient LUTs.
module tb_da_fir_seq;

  localparam int DATA_W = 16;
  localparam int TAPS   = 64;
  localparam int LUTS   = 8;
  localparam int LUT_W  = 32;
  localparam int ACC_W  = 48;

  localparam int H [TAPS] = '{
    123457, -7, 12, -20, 31, -45, 60, -78, 100, -123, 150, -180, 211, -245, 280, -318,
    357, -398, 440, -483, 527, -571, 616, -661, 705, -750, 794, -838, 881, -923, 964, -1004,
    1000, -990, 975, -950, 920, -885, 845, -800, 750, -700, 645, -590, 535, -480, 425, -370,
    315, -260, 210, -165, 125, -90, 60, -35, -94, -62, 39, 22, -12, -5, 1, 1
  };

  localparam logic [15:0] CV [4] = '{16'h7FFF, 16'hFFFF, 16'h1234, 16'hA5A5};

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [DATA_W-1:0]     in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  clear;
  logic [TAPS-1:0]       lut_addr;
  logic [LUTS*LUT_W-1:0] lut_data;
  logic [ACC_W-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;

  int          checks   = 0;
  int          failures = 0;
  longint      cyc      = 0;
  longint      last_acc = -1;
  longint      last_send_cyc = 0;
  logic        ov_prev  = 1'b0;
  logic [47:0] mon_exp;
  logic [47:0] exp_q [$];
  longint      xm [TAPS];

  da_fir_seq #(
    .DATA_W(DATA_W), .TAPS(TAPS), .LUTS(LUTS), .LUT_W(LUT_W), .ACC_W(ACC_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .clear    (clear),
    .lut_addr (lut_addr),
    .lut_data (lut_data),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // LUT j returns the sum of h over the taps whose address bit is set.
  function automatic logic [31:0] lut_eval(input logic [7:0] a, input int j);
    int s;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      if (a[i]) s += H[8*j+i];
    end
    return s;
  endfunction

  always_comb begin
    lut_data = '0;
    for (int j = 0; j < LUTS; j++) begin
      lut_data[LUT_W*j +: LUT_W] = lut_eval(lut_addr[8*j +: 8], j);
    end
  end

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [47:0] model_push(input logic [15:0] d);
    longint s;
    s = 0;
    for (int t = TAPS-1; t > 0; t--) xm[t] = xm[t-1];
    xm[0] = longint'($signed(d));
    for (int t = 0; t < TAPS; t++) s += longint'(H[t]) * xm[t];
    return s[47:0];
  endfunction

  task automatic model_clear();
    for (int t = 0; t < TAPS; t++) xm[t] = 0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [15:0] d, input logic [47:0] hand, input bit use_hand,
                      input bit do_push, input bit hold);
    int n;
    logic [47:0] m;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    m = model_push(d);
    if (do_push) exp_q.push_back(use_hand ? hand : m);
    last_send_cyc = cyc;
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    @(negedge clk);
  endtask

  // Monitor: latency, handshake exclusivity and scoreboard comparison.
  always @(negedge clk) begin
    #1;
    if (!rst_n || clear) begin
      last_acc = -1;
    end else begin
      if (in_valid && in_ready) last_acc = cyc;
      if (out_valid && !ov_prev) begin
        if (last_acc >= 0) chk("latency", cyc - last_acc, 17);
        else chk("spurious_valid", out_valid, 0);
      end
      chk("hs_overlap", in_ready & out_valid, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: actual=0x%0h required=none", out_data);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("out_data", out_data, mon_exp);
        end
      end
    end
    ov_prev = out_valid;
  end

  initial begin
    logic [47:0] e;
    logic [47:0] od;
    longint ac [4];
    longint hcyc;

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_lut_addr", lut_addr, 0);
    chk("rst_in_ready", in_ready, 1);

    // Impulse response: output k must equal h[k].
    for (int k = 0; k < TAPS; k++) begin
      e = 48'(H[k]);
      send((k == 0) ? 16'd1 : 16'd0, e, 1'b1, 1'b1, 1'b0);
    end
    drain();
    $display("impulse: 64 samples issued");

    // Negative full-scale into a zeroed line, then a second sample.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    e = 48'd0 - 48'd4045438976;
    send(16'h8000, e, 1'b1, 1'b1, 1'b0);
    send(16'd5, 48'd846661, 1'b1, 1'b1, 1'b0);
    drain();
    $display("neg_full_scale: issued");

    // in_valid held high: accepts must be 18 cycles apart.
    for (int i = 0; i < 4; i++) begin
      send(CV[i], 48'd0, 1'b0, 1'b1, 1'b1);
      ac[i] = last_send_cyc;
    end
    in_valid = 1'b0;
    for (int i = 1; i < 4; i++) chk("accept_spacing", ac[i] - ac[i-1], 18);
    drain();
    $display("continuous: 4 samples issued");

    // Backpressure in DONE.
    out_ready = 1'b0;
    send(16'h0123, 48'd0, 1'b0, 1'b1, 1'b0);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("bp_valid_timeout", out_valid, 1);
    end
    od = out_data;
    in_data = 16'h0456;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid_hold", out_valid, 1);
      chk("bp_data_hold", out_data, od);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    hcyc = cyc;
    @(negedge clk);
    chk("bp_ov_drop", out_valid, 0);
    chk("bp_accept_next", in_ready, 1);
    chk("bp_accept_cycle", cyc - hcyc, 1);
    e = model_push(16'h0456);
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    drain();
    $display("backpressure: issued");

    // clear mid-RUN at bit_cnt = 7, then clear in IDLE with a sample presented.
    send(16'h00FF, 48'd0, 1'b0, 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    chk("clr_run_addr", lut_addr[0], 1);
    clear = 1'b1; in_valid = 1'b1; in_data = 16'h0055;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    model_clear();
    chk("clr_out_valid", out_valid, 0);
    chk("clr_in_ready", in_ready, 1);
    chk("clr_lut_addr", lut_addr, 0);
    clear = 1'b1; in_valid = 1'b1; in_data = 16'h4000;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_drop_idle", in_ready, 1);
    send(16'd1, 48'd123457, 1'b1, 1'b1, 1'b0);
    drain();
    $display("clear: issued");

    // Asynchronous reset mid-RUN.
    send(16'h0F0F, 48'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rr_run_addr", lut_addr[0], 1);
    rst_n = 1'b0;
    #1;
    chk("rr_lut_addr", lut_addr, 0);
    chk("rr_out_valid", out_valid, 0);
    chk("rr_out_data", out_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    chk("rr_in_ready", in_ready, 1);
    send(16'd1, 48'd123457, 1'b1, 1'b1, 1'b0);
    drain();
    $display("reset_mid_run: issued");

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/da_fir_seq.md
Name: da_fir_seq

Overview:
Bit-serial distributed-arithmetic sequencer for the 64-tap DA FIR filter.
- Holds the sample delay line.
- Each cycle, drives the address inputs of the eight 8-input coefficient LUTs (taps 0-7 … 56-63).
- Sums the eight LUT outputs and shift-accumulates them over DATA_W bit-planes, with sign-bit subtraction.
- Presents one filtered output per accepted input sample over valid/ready handshakes.
- The LUTs are combinational and sit outside this block.

Parameters:
- DATA_W, 16, input sample width, two's complement.
- TAPS, 64, filter length; fixed to 8 × LUTS.
- LUTS, 8, number of 8-address coefficient LUTs.
- LUT_W, 32, LUT data width, two's complement.
- ACC_W, 48, accumulator/output width; must be ≥ DATA_W+LUT_W.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  DATA_W  input sample.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- clear  in  1  synchronous flush: zero the delay line and abort any computation.
- lut_addr  out  TAPS  LUT addresses; bits [8j+7:8j] go to LUT j; bit 8j+i belongs to tap 8j+i.
- lut_data  in  LUTS*LUT_W  LUT outputs; LUT j at [LUT_W*(j+1)-1:LUT_W*j]; same-cycle combinational return.
- out_data  out  ACC_W  filtered result y = Σ h[t]·x[t].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.

Behaviour:
- Delay line x[0..63], each DATA_W bits; x[0] is the newest sample.
  - On an input handshake: x[t] ← x[t-1] for t = 63..1, and x[0] ← in_data.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: shift the delay line, bit_cnt ← 0, acc ← 0, go to RUN.
- RUN:
  - in_ready = 0.
  - lut_addr[t] = x[t][bit_cnt] for every t.
  - sum = Σ over the 8 lut_data words, each sign-extended to ACC_W. This is combinational within the cycle.
  - For bit_cnt < DATA_W-1: acc ← acc + (sum << bit_cnt).
  - For bit_cnt = DATA_W-1 (sign plane): acc ← acc − (sum << bit_cnt), then go to DONE.
  - bit_cnt increments by 1 each cycle and does not wrap inside RUN.
- DONE:
  - out_valid = 1 and out_data = acc. Both hold stable while out_ready = 0.
  - On out_ready: go to IDLE. out_valid drops on the next cycle.
- lut_addr is 0 in IDLE and DONE.
- Latency: input handshake at cycle 0 → RUN for cycles 1..DATA_W → out_valid first high at cycle DATA_W+1 (17 with defaults).
- Minimum throughput: one sample per DATA_W+2 cycles.
- Input and output handshakes never overlap. in_ready is low in DONE, so a new sample is accepted no earlier than the cycle after the output handshake.
- clear:
  - Takes priority over every other event in the same cycle.
  - Zeroes x, acc and bit_cnt; the FSM goes to IDLE.
  - out_valid goes to 0 next cycle. Any pending result is discarded.
  - A sample presented with in_valid in the clear cycle is dropped.
- Arithmetic is exact two's complement and wraps modulo 2^ACC_W. No saturation; overflow cannot occur with the defaults.
- Reset (async assert, sync-released use):
  - FSM = IDLE, x = 0, acc = 0, bit_cnt = 0.
  - out_valid = 0, out_data = 0, in_ready = 1 after release, lut_addr = 0.
  - Reset mid-RUN or mid-DONE abandons the computation with no output.

Test Plan:
- Impulse: after reset, in_data = 1 then 63 samples of 0, out_ready = 1.
  - Required: output k equals h[k].
  - Outputs 56..63 must read −94, −62, 39, 22, −12, −5, 1, 1.
- Negative full-scale: with the delay line zero, in_data = −32768.
  - Required: out_data = −32768·h[0], exact and sign-extended to 48 bits.
  - Exercises sign-plane subtraction.
- Latency/handshake: in_valid held high continuously.
  - in_ready high only in IDLE; out_valid rises exactly 17 cycles after each accepted sample.
  - Accept spacing is 18 cycles.
- Backpressure: out_ready = 0 for 10 cycles in DONE.
  - out_data/out_valid stable; in_ready stays 0; no sample accepted.
  - After out_ready = 1, the next sample is accepted one cycle later.
- clear mid-RUN at bit_cnt = 7.
  - No out_valid for that sample; the next impulse input 1 yields output h[0] (delay line was zeroed).
- rst_n asserted mid-RUN, then released.
  - All outputs at reset values immediately (asynchronous); the first subsequent impulse yields h[0].
